// File: rtl/flatten_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : flatten_scheduler
// Brief    : Round-robin scheduler sharing one flattening PE between channel
//            pixel streams. Define FLAT_SCHED_TIMEOUT_EN for a WAIT_DONE timeout.
// Revision : 1.0 - initial release
// ============================================================================
module flatten_scheduler #(
    parameter int BitSize       = 4,
    parameter int ImageSize     = 9,
    parameter int Channels      = 4,
    parameter int Delay         = 3,
    parameter int TimeoutCycles = 64
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [Channels-1:0]           in_valid,
    input  logic [Channels*BitSize-1:0]   in_data,
    output logic [Channels-1:0]           in_ready,
    output logic                          pe_clear,
    output logic                          pe_valid,
    output logic [BitSize-1:0]            pe_data,
    input  logic                          pe_done,
    output logic                          out_done,
    output logic [$clog2(Channels)-1:0]   out_ch,
    output logic                          busy
`ifdef FLAT_SCHED_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    localparam int c_CH_W = $clog2(Channels);
    localparam int c_BT_W = $clog2(ImageSize + 1);
    localparam int c_FL_W = (Delay > 0) ? $clog2(Delay + 1) : 1;

    localparam logic [c_CH_W-1:0] c_LAST_CH    = c_CH_W'(Channels - 1);
    localparam logic [c_BT_W-1:0] c_LAST_BEAT  = c_BT_W'(ImageSize - 1);
    localparam logic [c_FL_W-1:0] c_LAST_FLUSH = c_FL_W'((Delay > 0) ? Delay - 1 : 0);

    if (ImageSize < 1 || Channels < 2 || Delay < 0 || TimeoutCycles < 1) begin : g_param_guard
        $error("flatten_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_STREAM    = 3'd2,
        S_FLUSH     = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [c_CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_CH_W-1:0]   grant_q, grant_d;
    logic [c_BT_W-1:0]   beat_q, beat_d;
    logic [c_FL_W-1:0]   flush_q, flush_d;
    logic                done_seen_q, done_seen_d;
    logic [c_CH_W-1:0]   out_ch_q, out_ch_d;

    logic [c_CH_W-1:0]   w_rr_sel;
    logic [c_CH_W-1:0]   w_next_ptr;
    logic [BitSize-1:0]  w_grant_data;

`ifdef FLAT_SCHED_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TimeoutCycles + 1);
    localparam logic [c_TO_W-1:0] c_LAST_WAIT = c_TO_W'(TimeoutCycles - 1);

    logic [c_TO_W-1:0]   wait_q, wait_d;
    logic                timeout_err_q, timeout_err_d;

    assign timeout_err = timeout_err_q;
`endif

    // First requester at or after rr_ptr; the descending loop lets the
    // smallest offset win.
    always_comb begin : rr_search
        int               idx;
        logic [c_CH_W-1:0] sel;
        idx      = 0;
        sel      = '0;
        w_rr_sel = rr_ptr_q;
        for (int i = Channels - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= Channels) begin
                idx = idx - Channels;
            end
            sel = c_CH_W'(idx);
            if (in_valid[sel]) begin
                w_rr_sel = sel;
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int c = 0; c < Channels; c++) begin
            if (grant_q == c_CH_W'(c)) begin
                w_grant_data = in_data[c*BitSize +: BitSize];
            end
        end
    end

    assign w_next_ptr = (grant_q == c_LAST_CH) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_d      = beat_q;
        flush_d     = flush_q;
        done_seen_d = done_seen_q;
        out_ch_d    = out_ch_q;
        in_ready    = '0;
        pe_clear    = 1'b0;
        pe_valid    = 1'b0;
        pe_data     = '0;
        out_done    = 1'b0;
`ifdef FLAT_SCHED_TIMEOUT_EN
        wait_d        = wait_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|in_valid) begin
                    grant_d = w_rr_sel;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                pe_clear    = 1'b1;
                beat_d      = '0;
                flush_d     = '0;
                done_seen_d = 1'b0;
`ifdef FLAT_SCHED_TIMEOUT_EN
                wait_d      = '0;
`endif
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                in_ready[grant_q] = 1'b1;
                pe_valid          = in_valid[grant_q];
                pe_data           = w_grant_data;
                if (pe_done) begin
                    done_seen_d = 1'b1;
                end
                if (in_valid[grant_q]) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == c_LAST_BEAT) begin
                        state_d = (Delay > 0) ? S_FLUSH : S_WAIT_DONE;
                    end
                end
            end
            S_FLUSH: begin
                pe_valid = 1'b1;
                if (pe_done) begin
                    done_seen_d = 1'b1;
                end
                if (flush_q == c_LAST_FLUSH) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                // A done that arrived while streaming or flushing counts here.
                if (pe_done || done_seen_q) begin
                    out_ch_d = grant_q;
                    state_d  = S_REPORT;
                end
`ifdef FLAT_SCHED_TIMEOUT_EN
                else if (wait_q == c_LAST_WAIT) begin
                    rr_ptr_d      = w_next_ptr;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_REPORT: begin
                out_done = 1'b1;
                rr_ptr_d = w_next_ptr;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_ch = out_ch_q;
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            done_seen_q <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            done_seen_q <= done_seen_d;
            out_ch_q    <= out_ch_d;
        end
    end

`ifdef FLAT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (res) begin
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/flatten_scheduler.md
# flatten_scheduler

Round-robin scheduler that shares one flattening PE between several convolution-channel pixel streams. It grants one channel at a time and clears the PE before each image. It then forwards exactly ImageSize pixels, appends Delay zero-valued flush beats, waits for the PE's done, and reports which channel's image has completed. It sits between the last convolution stage's per-channel outputs and the flattening PE feeding the dense layers.

## Interface
- BitSize, 4, pixel width in bits
- ImageSize, 9, pixels per image (ImageWidth*ImageWidth), ≥1
- Channels, 4, number of requesting channels, ≥2
- Delay, 3, zero-valued flush beats appended after each image, ≥0
- TimeoutCycles, 64, WAIT_DONE limit (used only with FLAT_SCHED_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- res  in  1  reset, synchronous, active-high
- in_valid  in  Channels  per-channel pixel valid
- in_data  in  Channels*BitSize  per-channel pixel, channel c at [c*BitSize +: BitSize]
- in_ready  out  Channels  one-hot ready to the granted channel, STREAM only
- pe_clear  out  1  one-cycle PE clear pulse at grant
- pe_valid  out  1  pixel valid to PE
- pe_data  out  BitSize  pixel to PE
- pe_done  in  1  PE has a complete flattened image
- out_done  out  1  one-cycle pulse: image of channel out_ch finished
- out_ch  out  $clog2(Channels)  channel just finished, held until next report
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse (present only with the macro)

## Operation
- States: IDLE, GRANT, STREAM, FLUSH, WAIT_DONE, REPORT.
- IDLE: if any in_valid is high, latch grant g = first c with in_valid[c] searching rr_ptr, rr_ptr+1, … with wrap-around; go to GRANT. Otherwise stay.
- GRANT: pe_clear=1 for this cycle only; clear beat counter and done_seen; go to STREAM.
- STREAM: in_ready[g]=1, others 0. pe_valid=in_valid[g] and pe_data=in_data[g], both combinational. A beat transfers when in_valid[g]&&in_ready[g], and the counter increments.
  - On the ImageSize-th transfer, go to FLUSH if Delay>0, else WAIT_DONE.
  - in_valid low stalls without timeout.
- FLUSH: pe_valid=1, pe_data=0 for exactly Delay cycles, then WAIT_DONE.
- done_seen sets on pe_done in STREAM or FLUSH. pe_done in IDLE, GRANT or REPORT is ignored.
- WAIT_DONE: if pe_done or done_seen, go to REPORT.
- REPORT: out_done=1, out_ch=g, rr_ptr=(g+1) mod Channels; go to IDLE.
- Outside STREAM/FLUSH: pe_valid=0, pe_data=0, in_ready=0.
- Non-granted channels are never acknowledged. Their in_valid may stay high indefinitely.
- Beat counter width is $clog2(ImageSize+1). Flush counter width is $clog2(Delay+1). Neither counter ever wraps.

## Timing
- Reset values: state IDLE; rr_ptr=0; g=0; counters=0; done_seen=0; in_ready=0; pe_clear=0; pe_valid=0; pe_data=0; out_done=0; out_ch=0; busy=0; timeout_err=0.
- res high mid-image: the next edge returns to IDLE with all reset values. No out_done is issued, and the partial image is abandoned. The PE is cleared at the next GRANT.
- Minimum image turnaround, with continuous valid and pe_done arriving in the first WAIT_DONE cycle:
  - 1 (IDLE) + 1 (GRANT) + ImageSize + Delay + 1 (WAIT_DONE) + 1 (REPORT) cycles.
- Back-to-back requests: there is always at least one IDLE cycle between REPORT and the next GRANT.
- out_done and pe_clear are never high in the same cycle.

## Configuration
- FLAT_SCHED_TIMEOUT_EN defined:
  - A WAIT_DONE cycle counter runs.
  - If TimeoutCycles cycles pass in WAIT_DONE without pe_done, timeout_err pulses for one cycle and the state returns to IDLE.
  - No out_done is issued; rr_ptr still advances to g+1.
- Not defined: the timeout_err port and the counter are absent, and WAIT_DONE waits indefinitely.

## Test plan
(Channels=2, ImageSize=9, Delay=3, BitSize=4 unless stated.)
- Reset: hold res for 2 cycles with in_valid=2'b11 -> all outputs 0, state IDLE. After release, GRANT to ch0 on the second cycle, pe_clear pulses once.
- Single image: ch0 sends 1..9 continuously, pe_done 1 cycle after the last flush beat -> pe_data 1..9 then 0,0,0 with pe_valid high for 12 cycles; out_done=1 with out_ch=0 exactly 15 cycles after the first IDLE-with-valid cycle.
- Round-robin: both channels valid continuously -> grants alternate ch0, ch1, ch0; in_ready[1] stays 0 throughout ch0's image.
- Stall: ch1 drops in_valid for 3 cycles after pixel 4 -> pe_valid low for those 3 cycles, total beats still 9, no extra flush beats.
- Early done plus mid-image reset: pe_done asserted during FLUSH -> REPORT follows one WAIT_DONE cycle. Separately, res pulsed after pixel 5 -> no out_done, and the next image starts with pe_clear.
- Timeout (macro defined, TimeoutCycles=8): pe_done never asserted -> timeout_err pulses 8 cycles after entering WAIT_DONE, no out_done, next grant goes to the other channel.
